// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time instruction-memory writer. Receives a byte stream over a
//   valid/ready link and packs each group of four bytes into a big-endian
//   32-bit word. Each word is written to the IM port at BASE_ADDR + 4*index.
//   cpu_hold stays asserted until the whole image has been written without
//   error.
//
//   Optional feature: define LOADER_CHECKSUM_EN to enable a trailing 32-bit
//   checksum. It is the sum mod 2^32 of all written words, sent big-endian
//   after the last word. A checksum mismatch sets err.
//
// Ports
//   clk, reset        system clock; synchronous active-low reset
//   start             one-cycle pulse, begins a load when idle/done
//   word_count        number of words to load, sampled on accepted start
//   rx_data/rx_valid  incoming byte stream
//   rx_ready          byte accepted this cycle when rx_valid is also high
//   im_cs/im_wr/im_rd IM control (im_rd tied low)
//   im_addr/im_din    IM byte address / write data
//   busy/done/err     load status
//   cpu_hold          keeps the CPU in reset while high
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int unsigned NUM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] word_count,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        im_cs,
   output logic        im_wr,
   output logic        im_rd,
   output logic [31:0] im_addr,
   output logic [31:0] im_din,
   output logic        busy,
   output logic        done,
   output logic        cpu_hold,
   output logic        err
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned PART_W = 24;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3
`ifdef LOADER_CHECKSUM_EN
      ,S_CHK  = 3'd4
`endif
   } state_t;

   state_t              state_q, state_n;
   logic [1:0]          byte_cnt_q, byte_cnt_n;
   logic [PART_W-1:0]   part_q, part_n;      // first three bytes of the word in flight
   logic [CNT_W-1:0]    idx_q, idx_n;
   logic [CNT_W-1:0]    count_q, count_n;
   logic [WORD_W-1:0]   word_full;
   logic                byte_fire;

   logic                rx_ready_n, im_cs_n, im_wr_n, busy_n, done_n, cpu_hold_n, err_n;
   logic [WORD_W-1:0]   im_addr_n, im_din_n;

`ifdef LOADER_CHECKSUM_EN
   logic [WORD_W-1:0]   sum_q, sum_n;
`endif

   // Read port is never used by the loader.
   assign im_rd = 1'b0;

   // Next-state and next-output logic.
   always_comb begin
      state_n    = state_q;
      byte_cnt_n = byte_cnt_q;
      part_n     = part_q;
      idx_n      = idx_q;
      count_n    = count_q;
      err_n      = err;
      im_addr_n  = im_addr;
      im_din_n   = im_din;
`ifdef LOADER_CHECKSUM_EN
      sum_n      = sum_q;
`endif
      // rx_ready is registered and equals "state is receiving", so this is the real handshake.
      byte_fire  = rx_valid && rx_ready;
      word_full  = {part_q, rx_data};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               count_n    = word_count;
               idx_n      = '0;
               byte_cnt_n = '0;
               err_n      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               sum_n      = '0;
`endif
               if (word_count == '0) begin
                  state_n = S_DONE;
               end else if (32'(word_count) > NUM_WORDS) begin
                  err_n   = 1'b1;
                  state_n = S_DONE;
               end else begin
                  state_n = S_RECV;
               end
            end
         end

         S_RECV: begin
            if (byte_fire) begin
               part_n     = word_full[PART_W-1:0];
               byte_cnt_n = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_n   = S_WRITE;
                  im_din_n  = word_full;
                  im_addr_n = BASE_ADDR + 32'({idx_q, 2'b00});
`ifdef LOADER_CHECKSUM_EN
                  sum_n     = sum_q + word_full;
`endif
               end
            end
         end

         S_WRITE: begin
            idx_n      = idx_q + 16'd1;
            byte_cnt_n = '0;
            if (16'(idx_q + 16'd1) == count_q) begin
`ifdef LOADER_CHECKSUM_EN
               state_n = S_CHK;
`else
               state_n = S_DONE;
`endif
            end else begin
               state_n = S_RECV;
            end
         end

`ifdef LOADER_CHECKSUM_EN
         S_CHK: begin
            if (byte_fire) begin
               part_n     = word_full[PART_W-1:0];
               byte_cnt_n = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (word_full != sum_q) err_n = 1'b1;
                  state_n = S_DONE;
               end
            end
         end
`endif

         default: state_n = S_IDLE;
      endcase

      // Outputs are registered versions of the decode of the upcoming state.
      rx_ready_n = (state_n == S_RECV)
`ifdef LOADER_CHECKSUM_EN
                   || (state_n == S_CHK)
`endif
                   ;
      im_cs_n    = (state_n == S_WRITE);
      im_wr_n    = (state_n == S_WRITE);
      busy_n     = (state_n != S_IDLE) && (state_n != S_DONE);
      done_n     = (state_n == S_DONE);
      cpu_hold_n = (state_n == S_DONE) ? err_n : 1'b1;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= '0;
         part_q     <= '0;
         idx_q      <= '0;
         count_q    <= '0;
         rx_ready   <= 1'b0;
         im_cs      <= 1'b0;
         im_wr      <= 1'b0;
         im_addr    <= BASE_ADDR;
         im_din     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpu_hold   <= 1'b1;
         err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_n;
         byte_cnt_q <= byte_cnt_n;
         part_q     <= part_n;
         idx_q      <= idx_n;
         count_q    <= count_n;
         rx_ready   <= rx_ready_n;
         im_cs      <= im_cs_n;
         im_wr      <= im_wr_n;
         im_addr    <= im_addr_n;
         im_din     <= im_din_n;
         busy       <= busy_n;
         done       <= done_n;
         cpu_hold   <= cpu_hold_n;
         err        <= err_n;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= sum_n;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed + randomized bench for imem_loader. The expected IM writes are
//   computed from the byte stream alone. Word i is bytes 4i..4i+3, big-endian,
//   written at BASE + 4*i. The base is placed near the top of the address
//   space so longer loads wrap through zero.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'hFFFF_FFF0;
   localparam int          NUMW = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] word_count;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready, im_cs, im_wr, im_rd, busy, done, cpu_hold, err;
   logic [31:0] im_addr, im_din;

   int vectors     = 0;
   int miscompares = 0;
   int cs_pulses   = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [7:0]  stim[$];

   imem_loader #(.BASE_ADDR(BASE), .NUM_WORDS(NUMW)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .im_cs(im_cs), .im_wr(im_wr), .im_rd(im_rd), .im_addr(im_addr), .im_din(im_din),
      .busy(busy), .done(done), .cpu_hold(cpu_hold), .err(err)
   );

   always #5 clk = ~clk;

   // Write-port monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (im_cs) cs_pulses <= cs_pulses + 1;
      if (im_cs && im_wr) begin
         wr_addr_q.push_back(im_addr);
         wr_data_q.push_back(im_din);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".rx_ready"}, 32'(rx_ready), 32'd0);
      chk({tag, ".im_cs"},    32'(im_cs),    32'd0);
      chk({tag, ".im_wr"},    32'(im_wr),    32'd0);
      chk({tag, ".im_rd"},    32'(im_rd),    32'd0);
      chk({tag, ".im_addr"},  im_addr,       BASE);
      chk({tag, ".im_din"},   im_din,        32'd0);
      chk({tag, ".busy"},     32'(busy),     32'd0);
      chk({tag, ".done"},     32'(done),     32'd0);
      chk({tag, ".err"},      32'(err),      32'd0);
      chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'd1);
   endtask

   task automatic do_start(input int cnt);
      @(negedge clk);
      start      = 1'b1;
      word_count = 16'(cnt);
      sync();
      start      = 1'b0;
   endtask

   // Present one byte after `gap` idle cycles and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited = 0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("rx_ready_wait", 32'(rx_ready), 32'd1);
      sync();
      rx_valid = 1'b0;
   endtask

   task automatic fill_rand(input int n);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom_range(255, 0)));
   endtask

   // Run one load using bytes from `stim` and check everything against the model.
   task automatic do_load(input int cnt, input int gap_lo, input int gap_hi,
                          input logic [31:0] ck_delta, input bit poke);
      logic [31:0] exp_addr[$];
      logic [31:0] exp_data[$];
      logic [31:0] sum = 32'd0;
      bit          exp_err;
      int          n_exp, wr_base, cs_base, got;

      exp_err = (cnt > NUMW);
      n_exp   = (exp_err || cnt == 0) ? 0 : cnt;
      for (int i = 0; i < n_exp; i++) begin
         exp_data.push_back({stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]});
         exp_addr.push_back(BASE + 32'(4 * i));
         sum += exp_data[i];
      end

      sync();
      wr_base = wr_addr_q.size();
      cs_base = cs_pulses;
      do_start(cnt);
      if (n_exp == 0) begin
         chk("start.done_next", 32'(done), 32'd1);
         chk("start.busy_low",  32'(busy), 32'd0);
      end else begin
         chk("start.busy",     32'(busy),     32'd1);
         chk("start.done_clr", 32'(done),     32'd0);
         chk("start.hold",     32'(cpu_hold), 32'd1);
      end

      for (int b = 0; b < 4 * n_exp; b++) begin
         send_byte(stim[b], $urandom_range(gap_hi, gap_lo));
         if (poke && b == 0) begin
            @(negedge clk);
            start      = 1'b1;
            word_count = 16'd0;
            sync();
            start      = 1'b0;
            chk("busy_start_ignored", 32'(busy), 32'd1);
         end
      end

`ifdef LOADER_CHECKSUM_EN
      if (n_exp > 0) begin
         logic [31:0] ck;
         ck = sum + ck_delta;
         send_byte(ck[31:24], 0);
         send_byte(ck[23:16], 0);
         send_byte(ck[15:8],  0);
         send_byte(ck[7:0],   0);
         if (ck_delta != 32'd0) exp_err = 1'b1;
      end
`else
      if (ck_delta != 32'd0) exp_err = exp_err;
`endif

      for (int i = 0; i < 200 && !done; i++) @(negedge clk);
      chk("end.done",     32'(done),     32'd1);
      chk("end.busy",     32'(busy),     32'd0);
      chk("end.err",      32'(err),      32'(exp_err));
      chk("end.cpu_hold", 32'(cpu_hold), 32'(exp_err));
      chk("end.rx_ready", 32'(rx_ready), 32'd0);
      chk("end.im_rd",    32'(im_rd),    32'd0);

      got = wr_addr_q.size() - wr_base;
      chk("end.num_writes", 32'(got), 32'(n_exp));
      chk("end.cs_cycles",  32'(cs_pulses - cs_base), 32'(n_exp));
      for (int i = 0; i < n_exp && i < got; i++) begin
         chk($sformatf("wr_addr[%0d]", i), wr_addr_q[wr_base + i], exp_addr[i]);
         chk($sformatf("wr_data[%0d]", i), wr_data_q[wr_base + i], exp_data[i]);
      end
   endtask

   initial begin
      int wr_base;
      reset      = 1'b0;
      start      = 1'b0;
      word_count = 16'd0;
      rx_data    = 8'd0;
      rx_valid   = 1'b0;
      repeat (3) sync();
      chk_reset_vals("reset");
      @(negedge clk);
      reset = 1'b1;

      // Two words back-to-back.
      stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
      do_load(2, 0, 0, 32'd0, 1'b0);

      // Same image with three idle cycles before each byte.
      do_load(2, 3, 3, 32'd0, 1'b0);

      // Empty image.
      stim.delete();
      do_load(0, 0, 0, 32'd0, 1'b0);

      // Too many words: error, CPU kept in reset.
      do_load(NUMW + 1, 0, 0, 32'd0, 1'b0);

      // Largest legal image, random gaps; addresses wrap through zero.
      fill_rand(4 * NUMW);
      do_load(NUMW, 0, 2, 32'd0, 1'b0);

      // start pulse while busy must not disturb the load.
      fill_rand(12);
      do_load(3, 0, 1, 32'd0, 1'b1);

      // Reset in the middle of word 0, coincident with a start pulse.
      sync();
      wr_base = wr_addr_q.size();
      do_start(1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(negedge clk);
      reset      = 1'b0;
      start      = 1'b1;
      word_count = 16'd1;
      sync();
      start = 1'b0;
      chk_reset_vals("midreset");
      @(negedge clk);
      reset = 1'b1;
      repeat (3) sync();
      chk("midreset.no_write", 32'(wr_addr_q.size() - wr_base), 32'd0);
      chk("midreset.idle",     32'(busy), 32'd0);
      stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_load(1, 0, 0, 32'd0, 1'b0);

      // Random loads.
      for (int r = 0; r < 4; r++) begin
         int cnt;
         cnt = $urandom_range(5, 1);
         fill_rand(4 * cnt);
         do_load(cnt, 0, 2, (r % 2 == 1) ? 32'($urandom_range(1000, 1)) : 32'd0, 1'b0);
      end

`ifdef LOADER_CHECKSUM_EN
      // Checksum good then bad for words 1 and 2.
      stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
      do_load(2, 0, 0, 32'd0, 1'b0);
      do_load(2, 0, 0, 32'd1, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
